data_receiver: RTL
==================

# data_receiver

Receive-side counterpart of the 40-bit byte serializer. It takes a stream of byte strobes from the serial receive path and reassembles them into a word, least-significant byte first, the same order in which the serializer emits them. Each complete word is published on a held output register with a one-cycle valid pulse. An optional inter-byte timeout discards stale partial frames so the receiver resynchronises after a lost byte.

## Interface
Parameters:
- BYTES, 5: bytes per word; data_out width is 8*BYTES; legal range 2..16.
- TIMEOUT_CYCLES, 1000000: maximum idle gap in clk cycles between bytes of one frame; legal range ≥2; used only when the timeout is compiled in.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- byte_in  input  8  received byte; sampled only when byte_valid=1.
- byte_valid  input  1  single-cycle strobe, one per received byte; may be high on consecutive cycles.
- data_out  output  8*BYTES  last complete word; byte k occupies bits [8k+7:8k].
- data_valid  output  1  one-cycle pulse when data_out has just been updated.
- busy  output  1  high while a partial frame is held (byte count ≠ 0).
- frame_error  output  1  one-cycle pulse when a partial frame is discarded by timeout.

## Operation
- Reset (rst=0, async): data_out=0, data_valid=0, busy=0, frame_error=0, byte count=0, shadow register=0, state IDLE. Reset mid-frame drops all collected bytes.
- FSM states:
  - IDLE: count=0.
  - COLLECT: 0 < count < BYTES.
- IDLE with byte_valid: byte goes to shadow[7:0]; count=1; go to COLLECT.
- COLLECT with byte_valid: byte goes to shadow slot count; count increments.
- Final byte (count==BYTES-1 with byte_valid):
  - data_out ← {byte_in, shadow lower bytes}.
  - data_valid pulses.
  - count=0; go to IDLE.
- A byte_valid on the cycle after completion starts a new frame. No dead cycles.
- data_out changes only on completion. Partial frames never disturb it.
- The shadow register is not cleared between frames. Unwritten slots are always overwritten before use.
- busy = (count ≠ 0), registered.

## Timing
- Latency: data_out and data_valid are registered. Both take effect on the clock edge that samples the final byte_valid, so they are visible the cycle after that strobe.
- data_valid is high for exactly one cycle per completed word.
- Maximum throughput: one byte per cycle, i.e. one word per BYTES cycles.
- Timeout (when compiled in):
  - A gap counter clears on every byte_valid and increments each cycle in COLLECT without byte_valid.
  - At the edge where the counter would reach TIMEOUT_CYCLES, the receiver discards the frame: count=0, IDLE, frame_error pulses one cycle.
  - byte_valid on that same cycle wins. The byte is accepted, the counter clears, and there is no error.
  - The gap counter is inactive in IDLE.
- frame_error and data_valid are never high in the same cycle.

## Configuration
- Macro DATA_RECEIVER_TIMEOUT_EN.
- Defined: gap counter, timeout discard and frame_error are built as described in Timing.
- Undefined:
  - No gap counter logic.
  - frame_error is tied to 0.
  - A partial frame waits indefinitely for its remaining bytes.
  - TIMEOUT_CYCLES is ignored.

## Structure
- Shared package data_link_pkg:
  - BYTE_W=8.
  - DEFAULT_WORD_BYTES=5.
  - Receiver state enum {IDLE, COLLECT}.
  - The serializer reuses BYTE_W and DEFAULT_WORD_BYTES.
- Sub-module inter_byte_timer:
  - Parameter TIMEOUT_CYCLES.
  - Inputs clk, rst, clear, enable; output expired.
  - Instantiated only under DATA_RECEIVER_TIMEOUT_EN.
  - Counter width $clog2(TIMEOUT_CYCLES+1).

## Test plan
Bench uses BYTES=5 and TIMEOUT_CYCLES=16 throughout.
- Basic frame: bytes 0x55,0x44,0x33,0x22,0x11, one per 2 cycles -> data_out=0x1122334455 and data_valid pulses exactly once, one cycle after the 5th strobe; busy low afterwards.
- Back-to-back: ten consecutive-cycle strobes 0x55..0x11 then 0x9a,0x78,0x56,0x34,0x12 -> two data_valid pulses 5 cycles apart; data_out 0x1122334455 then 0x123456789a.
- Timeout discard (macro on): 3 bytes 0xaa,0xbb,0xcc, then 16 idle cycles -> frame_error pulses once; data_out keeps the prior word. Next 5 bytes 0x9a..0x12 -> 0x123456789a.
- Timeout boundary (macro on): byte_valid exactly on the 16th idle cycle -> no frame_error; the frame completes normally with the remaining bytes.
- Reset mid-frame: 2 bytes, then rst low for 1 cycle -> data_out=0, busy=0 immediately (async). Next 5 bytes 0x55..0x11 -> 0x1122334455.
- Macro off: 100-cycle gap between the 2nd and 3rd bytes -> frame still assembles to 0x1122334455; frame_error never asserts.

Source files
------------

// File: rtl/data_link_pkg.sv
// Shared byte-link definitions used by the serializer and the data_receiver.
package data_link_pkg;

    localparam int unsigned BYTE_W             = 8;
    localparam int unsigned DEFAULT_WORD_BYTES = 5;

    typedef enum logic {
        IDLE,
        COLLECT
    } rx_state_t;

endpackage

// File: rtl/inter_byte_timer.sv
// Idle-gap counter between received bytes; expired flags the cycle the gap reaches TIMEOUT_CYCLES.
module inter_byte_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] gap;

    // A byte arriving on the would-be expiry cycle suppresses the timeout.
    assign expired = enable && !clear && (gap == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gap <= '0;
        end else if (clear || !enable || expired) begin
            gap <= '0;
        end else begin
            gap <= gap + CNT_W'(1);
        end
    end

endmodule

// File: rtl/data_receiver.sv
// Reassembles LSB-first byte strobes into BYTES-wide words.
// Optional inter-byte timeout compiled in with DATA_RECEIVER_TIMEOUT_EN.
module data_receiver
    import data_link_pkg::*;
#(
    parameter int unsigned BYTES          = DEFAULT_WORD_BYTES,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BYTE_W-1:0]     byte_in,
    input  logic                  byte_valid,
    output logic [BYTE_W*BYTES-1:0] data_out,
    output logic                  data_valid,
    output logic                  busy,
    output logic                  frame_error
);

    localparam int unsigned CNT_W = $clog2(BYTES);
    localparam int unsigned SHD_W = BYTE_W * (BYTES - 1);

    generate
        if (BYTES < 2 || BYTES > 16) begin : g_bad_bytes
            $error("data_receiver: BYTES out of range");
        end
        if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
            $error("data_receiver: TIMEOUT_CYCLES out of range");
        end
    endgenerate

    rx_state_t        state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic [SHD_W-1:0] shadow;
    logic             complete;
    logic             discard;
    logic             expired;

`ifdef DATA_RECEIVER_TIMEOUT_EN
    inter_byte_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (byte_valid),
        .enable (state == COLLECT),
        .expired(expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_next = state;
        count_next = count;
        complete   = 1'b0;
        discard    = 1'b0;
        case (state)
            IDLE: begin
                if (byte_valid) begin
                    count_next = CNT_W'(1);
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (byte_valid) begin
                    if (count == CNT_W'(BYTES - 1)) begin
                        complete   = 1'b1;
                        count_next = '0;
                        state_next = IDLE;
                    end else begin
                        count_next = count + CNT_W'(1);
                    end
                end else if (expired) begin
                    discard    = 1'b1;
                    count_next = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                count_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            count       <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            busy        <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            data_valid  <= complete;
            busy        <= (count_next != '0);
            frame_error <= discard;
            if (complete) begin
                data_out <= {byte_in, shadow};
            end
        end
    end

    // Shadow holds the lower BYTES-1 bytes; the top byte goes straight to data_out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow <= '0;
        end else if (byte_valid) begin
            for (int unsigned i = 0; i < BYTES - 1; i++) begin
                if (count == CNT_W'(i)) begin
                    shadow[i*BYTE_W +: BYTE_W] <= byte_in;
                end
            end
        end
    end

endmodule
